// File: rtl/norflash_pkg.sv
// Shared types and helpers for the norflash prefetch line buffer.
package norflash_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIT  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam int unsigned WORD_W     = 32;
  localparam logic [3:0]  WB_SEL_ALL = 4'b1111;

  // Bits needed to index a word within a line.
  function automatic int unsigned idx_w(input int unsigned line_words);
    return (line_words > 1) ? int'($clog2(line_words)) : 1;
  endfunction

  // Byte-offset bits covered by one line.
  function automatic int unsigned offset_w(input int unsigned line_words);
    return idx_w(line_words) + 2;
  endfunction

endpackage

// File: rtl/norflash_prefetch_line.sv
// One cache line: LINE_WORDS x 32-bit storage with a valid bit per word.
module norflash_prefetch_line
  import norflash_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = idx_w(LINE_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [WORD_W-1:0]     i_wr_data,
  input  logic [IDX_W-1:0]      i_rd_idx,
  input  logic                  i_clr_all,
  output logic [WORD_W-1:0]     o_rd_data_c,
  output logic [LINE_WORDS-1:0] o_valid
);

  logic [WORD_W-1:0]     r_mem [LINE_WORDS];
  logic [LINE_WORDS-1:0] r_valid;

  // Word storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
  end

  // Valid bits; a clear takes priority over a same-cycle write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_valid <= '0;
    else if (i_clr_all) r_valid <= '0;
    else if (i_wr_en)   r_valid[i_wr_idx] <= 1'b1;
  end

  assign o_rd_data_c = r_mem[i_rd_idx];
  assign o_valid     = r_valid;

endmodule

// File: rtl/norflash_prefetch.sv
// Read-only prefetch line buffer between the CPU Wishbone bus and norflash.
// Misses fetch a whole aligned line in order with early restart.
// Optional hit/miss counters: define NORFLASH_PREFETCH_STATS_EN.
module norflash_prefetch
  import norflash_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADR_W      = 25
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wbs_adr_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        invalidate_i
`ifdef NORFLASH_PREFETCH_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = idx_w(LINE_WORDS);
  localparam int unsigned OFF_W = offset_w(LINE_WORDS);
  localparam int unsigned TAG_W = ADR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e            r_state, w_state_nxt;
  logic [TAG_W-1:0]  r_tag, w_tag_nxt, w_req_tag;
  logic [IDX_W-1:0]  r_fill_idx, w_idx_nxt, w_req_idx;
  logic [31:0]       r_dat, w_dat_nxt, r_madr, w_madr_nxt, w_line_rd;
  logic              r_ack, w_ack_nxt, r_err, w_err_nxt, r_mcyc, w_mcyc_nxt;
  logic              r_inv_pend, w_inv_nxt, r_pend, w_pend_nxt;
  logic              w_req, w_rd, w_wr, w_tag_hit, w_word_valid, w_fill_ack;
  logic              w_clr, w_wr_en, w_hit_inc, w_miss_inc;
  logic [LINE_WORDS-1:0] w_valid;
  logic              w_unused_in;

  assign w_req        = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
  assign w_rd         = w_req & ~wbs_we_i;
  assign w_wr         = w_req & wbs_we_i;
  assign w_req_tag    = wbs_adr_i[ADR_W-1:OFF_W];
  assign w_req_idx    = wbs_adr_i[OFF_W-1:2];
  assign w_tag_hit    = (w_req_tag == r_tag);
  assign w_word_valid = w_valid[w_req_idx];
  assign w_fill_ack   = (r_state == ST_FILL) & r_mcyc & wbm_ack_i;
  assign w_unused_in  = ^{wbs_sel_i, wbs_adr_i[31:ADR_W], wbs_adr_i[1:0]};

  norflash_prefetch_line #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_line (
    .i_clk       (sys_clk),
    .i_rst_n     (sys_rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_fill_idx),
    .i_wr_data   (wbm_dat_i),
    .i_rd_idx    (w_req_idx),
    .i_clr_all   (w_clr),
    .o_rd_data_c (w_line_rd),
    .o_valid     (w_valid)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, line fill sequencing and slave response decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = w_wr;
    w_dat_nxt   = r_dat;
    w_mcyc_nxt  = r_mcyc;
    w_madr_nxt  = r_madr;
    w_tag_nxt   = r_tag;
    w_idx_nxt   = r_fill_idx;
    w_inv_nxt   = r_inv_pend;
    w_pend_nxt  = r_pend & wbs_cyc_i;
    w_clr       = 1'b0;
    w_wr_en     = 1'b0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clr = invalidate_i;
        if (w_rd) begin
          if (w_tag_hit && w_word_valid && !invalidate_i) begin
            w_ack_nxt   = 1'b1;
            w_dat_nxt   = w_line_rd;
            w_hit_inc   = 1'b1;
            w_state_nxt = ST_HIT;
          end else begin
            w_clr       = 1'b1;
            w_tag_nxt   = w_req_tag;
            w_idx_nxt   = '0;
            w_mcyc_nxt  = 1'b1;
            w_madr_nxt  = 32'({w_req_tag, {IDX_W{1'b0}}, 2'b00});
            w_inv_nxt   = 1'b0;
            w_pend_nxt  = 1'b1;
            w_miss_inc  = 1'b1;
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_HIT: begin
        w_clr       = invalidate_i;
        w_state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        if (invalidate_i) w_inv_nxt = 1'b1;
        if (w_fill_ack) begin
          w_wr_en    = 1'b1;
          w_idx_nxt  = r_fill_idx + IDX_W'(1);
          w_mcyc_nxt = 1'b0;
          if (r_fill_idx == LAST_IDX) begin
            w_clr       = r_inv_pend | invalidate_i;
            w_inv_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (!r_mcyc) begin
          // One idle cycle separates consecutive master reads.
          w_mcyc_nxt = 1'b1;
          w_madr_nxt = 32'({r_tag, r_fill_idx, 2'b00});
        end
        if (w_rd && w_tag_hit) begin
          if (w_word_valid && !r_inv_pend && !invalidate_i) begin
            w_ack_nxt  = 1'b1;
            w_dat_nxt  = w_line_rd;
            w_hit_inc  = 1'b1;
            w_pend_nxt = 1'b0;
          end else if (w_fill_ack && (w_req_idx == r_fill_idx)) begin
            // Early restart: forward the arriving word straight to the slave.
            w_ack_nxt  = 1'b1;
            w_dat_nxt  = wbm_dat_i;
            w_miss_inc = ~r_pend;
            w_pend_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus outputs and datapath state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= '0;
      r_mcyc     <= 1'b0;
      r_madr     <= '0;
      r_tag      <= '0;
      r_fill_idx <= '0;
      r_inv_pend <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_dat      <= w_dat_nxt;
      r_mcyc     <= w_mcyc_nxt;
      r_madr     <= w_madr_nxt;
      r_tag      <= w_tag_nxt;
      r_fill_idx <= w_idx_nxt;
      r_inv_pend <= w_inv_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbm_adr_o = r_madr;
  assign wbm_sel_o = WB_SEL_ALL;
  assign wbm_cyc_o = r_mcyc;
  assign wbm_stb_o = r_mcyc;

`ifdef NORFLASH_PREFETCH_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Hit/miss counters, one increment per accepted read, free-running wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_inc) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_hit_inc ^ w_miss_inc;
`endif

endmodule

// File: tb/tb_norflash_prefetch.sv
// Directed self-checking bench for norflash_prefetch with a 4-cycle flash model.
module tb_norflash_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_ack_i, invalidate_i;
`ifdef NORFLASH_PREFETCH_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int last_mack_edge = 0;
  int n_mcyc = 0;
  int fcnt;
  logic [31:0] madr_q [$];

  norflash_prefetch dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_err_o    (wbs_err_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_ack_i    (wbm_ack_i),
    .invalidate_i (invalidate_i)
`ifdef NORFLASH_PREFETCH_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Flash model: ack four cycles after strobe, data = address ^ A5A5_0000.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt      <= 0;
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= '0;
    end else if (wbm_stb_o && !wbm_ack_i) begin
      if (fcnt == 3) begin
        wbm_ack_i <= 1'b1;
        wbm_dat_i <= wbm_adr_o ^ 32'hA5A5_0000;
        fcnt      <= 0;
      end else begin
        fcnt <= fcnt + 1;
      end
    end else begin
      wbm_ack_i <= 1'b0;
      fcnt      <= 0;
    end
  end

  // Master bus monitor.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_n && wbm_cyc_o && wbm_ack_i) begin
      madr_q.push_back(wbm_adr_o);
      last_mack_edge <= cyc_cnt;
    end
    if (wbm_cyc_o) n_mcyc <= n_mcyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read; optionally pulses invalidate_i once master ack count reaches inv_at.
  task automatic wb_read(input logic [31:0] adr, input int inv_at,
                         output logic [31:0] dat, output int lat, output int ack_edge);
    logic ok, inv_sent;
    step();
    wbs_adr_i = adr; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    lat = 0; ok = 1'b0; inv_sent = 1'b0; dat = '0; ack_edge = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      lat++;
      invalidate_i = 1'b0;
      if (wbs_ack_o) begin
        dat = wbs_dat_o; ok = 1'b1; ack_edge = cyc_cnt - 1;
        break;
      end
      if (inv_at >= 0 && !inv_sent && madr_q.size() >= inv_at) begin
        invalidate_i = 1'b1; inv_sent = 1'b1;
      end
    end
    invalidate_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (!ok) chk("rd_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_fill(input string tag, input int target);
    for (int i = 0; i < 200; i++) begin
      if (madr_q.size() >= target && !wbm_cyc_o) break;
      step();
    end
    chk(tag, 32'(madr_q.size()), 32'(target));
  endtask

  logic [31:0] d;
  int lat, aedge, base, mc0;

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wbs_adr_i = '0; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; invalidate_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rst_err", 32'(wbs_err_o), 32'h0);
    chk("rst_madr", wbm_adr_o, 32'h0);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
    chk("rst_stb", 32'(wbm_stb_o), 32'h0);
    chk("sel_all", 32'(wbm_sel_o), 32'hF);
`ifdef NORFLASH_PREFETCH_STATS_EN
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_miss", miss_count, 32'h0);
`endif
    rst_n = 1'b1;

    // 1: cold read 0x0, early restart on first master ack.
    base = madr_q.size();
    wb_read(32'h0, -1, d, lat, aedge);
    chk("t1_data", d, 32'hA5A5_0000);
    chk("t1_nmack", 32'(madr_q.size() - base), 32'd1);
    chk("t1_restart", 32'(aedge), 32'(last_mack_edge));
    wait_fill("t1_fill", base + 4);
    for (int i = 0; i < 4; i++) chk("t1_madr", madr_q[base + i], 32'(4 * i));

    // 2: sequential hits, no master activity.
    mc0 = n_mcyc;
    for (int i = 1; i < 4; i++) begin
      wb_read(32'(4 * i), -1, d, lat, aedge);
      chk("t2_data", d, 32'hA5A5_0000 ^ 32'(4 * i));
      chk("t2_lat", 32'(lat), 32'd1);
    end
    chk("t2_nomaster", 32'(n_mcyc - mc0), 32'd0);

    // 3: miss on 0xFFF8, then hit on 0xFFF0 while the fill runs.
    base = madr_q.size();
    wb_read(32'h0000_FFF8, -1, d, lat, aedge);
    chk("t3_data", d, 32'hA5A5_FFF8);
    chk("t3_nmack", 32'(madr_q.size() - base), 32'd3);
    chk("t3_restart", 32'(aedge), 32'(last_mack_edge));
    chk("t3_first", madr_q[base], 32'h0000_FFF0);
    wb_read(32'h0000_FFF0, -1, d, lat, aedge);
    chk("t3_hit_data", d, 32'hA5A5_FFF0);
    chk("t3_hit_lat", 32'(lat), 32'd1);
    chk("t3_in_fill", 32'(madr_q.size() - base), 32'd3);
    wait_fill("t3_fill", base + 4);
    chk("t3_last", madr_q[base + 3], 32'h0000_FFFC);

    // 4: write rejected with a single err pulse, buffer intact.
    mc0 = n_mcyc;
    step();
    wbs_adr_i = 32'h10; wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step();
    chk("t4_err", 32'(wbs_err_o), 32'd1);
    chk("t4_noack", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    step();
    chk("t4_err_pulse", 32'(wbs_err_o), 32'd0);
    chk("t4_nomaster", 32'(n_mcyc - mc0), 32'd0);
    wb_read(32'h0000_FFF4, -1, d, lat, aedge);
    chk("t4_hit_data", d, 32'hA5A5_FFF4);
    chk("t4_hit_lat", 32'(lat), 32'd1);

    // 5: invalidate mid-fill; requested word still delivered, line dropped afterwards.
    base = madr_q.size();
    wb_read(32'h48, base + 1, d, lat, aedge);
    chk("t5_data", d, 32'hA5A5_0048);
    chk("t5_nmack", 32'(madr_q.size() - base), 32'd3);
    wait_fill("t5_fill", base + 4);
    base = madr_q.size();
    wb_read(32'h44, -1, d, lat, aedge);
    chk("t5_reread_data", d, 32'hA5A5_0044);
    chk("t5_reread_miss", 32'(lat > 1), 32'd1);
    chk("t5_refill_first", madr_q[base], 32'h40);
    wait_fill("t5_refill", base + 4);

    // 6: reset mid-fill drops the master cycle without waiting for ack.
    step();
    wbs_adr_i = 32'h80; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int i = 0; i < 20 && !wbm_cyc_o; i++) step();
    chk("t6_cyc_up", 32'(wbm_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    chk("t6_stb_drop", 32'(wbm_stb_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("t6_cyc_rel", 32'(wbm_cyc_o), 32'd0);
`ifdef NORFLASH_PREFETCH_STATS_EN
    chk("t6_rst_hits", hit_count, 32'h0);
    chk("t6_rst_miss", miss_count, 32'h0);
`endif
    base = madr_q.size();
    wb_read(32'h0, -1, d, lat, aedge);
    chk("t6_data", d, 32'hA5A5_0000);
    chk("t6_miss", 32'(madr_q.size() - base), 32'd1);
    chk("t6_first", madr_q[base], 32'h0);
    wait_fill("t6_fill", base + 4);
    wb_read(32'h4, -1, d, lat, aedge);
    chk("t6_hit_data", d, 32'hA5A5_0004);
    chk("t6_hit_lat", 32'(lat), 32'd1);
`ifdef NORFLASH_PREFETCH_STATS_EN
    chk("t6_hits", hit_count, 32'd1);
    chk("t6_misses", miss_count, 32'd1);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
